mprj_checkpoint_monitor: RTL
============================

Name: mprj_checkpoint_monitor

Overview:
Synthesizable checkpoint sequencer that watches a user-project GPIO field for an ordered list of firmware checkpoint codes. It reports pass, fail or timeout. It generalises the two-code wb_port check (0xAB60 then 0xAB61 within a cycle budget) to N steps, any field width, input glitch filtering and an optional strict-order mode. It sits between mprj_io[31:16] (or any slice) and a status register or bench scoreboard, so one block serves every DV test and the on-chip self-test.

Parameters:
WIDTH, 16, checkbit field width (1..32)
NUM_STEPS, 2, number of expected codes (1..8)
STEP_W, 3, width of step index; must satisfy 2**STEP_W >= NUM_STEPS+1
TIMEOUT_CYCLES, 70000, cycle budget from arm to pass; 0 disables timeout
CNT_W, 17, width of elapsed-cycle counter; must hold TIMEOUT_CYCLES
STABLE_CYCLES, 2, consecutive identical synchronised samples required to accept a value (>=1)
STRICT, 0, 1 = any accepted value other than the current or previous expected code causes fail

Ports:
clock  in  1  system clock
resetb  in  1  asynchronous active-low reset
enable  in  1  level; high arms and runs the monitor, low returns it to IDLE
checkbits  in  WIDTH  asynchronous GPIO field under observation
exp_codes  in  NUM_STEPS*WIDTH  expected codes; step k at bits [k*WIDTH +: WIDTH]; sampled only when arming
step_idx  out  STEP_W  number of codes matched so far
step_pulse  out  1  one-cycle pulse on each match
started  out  1  sticky; first code matched
pass  out  1  sticky; all codes matched in order
fail  out  1  sticky; strict violation or timeout
timeout  out  1  sticky; fail cause was timeout
fail_code  out  WIDTH  accepted value that caused a strict fail; 0 otherwise
cycles  out  CNT_W  cycles since arm; freezes in PASS/FAIL; saturates at all-ones

Behaviour:
- Reset (async, resetb low): state IDLE. All outputs 0, including the internal code shadow and the filter.
- Input path: 2-flop synchroniser, then stability counter. A value is "accepted" once it has been identical for STABLE_CYCLES consecutive post-sync cycles. It produces one accept strobe per distinct value, so a held value is not re-accepted.
- Latency: a clean change at checkbits produces step_pulse and step_idx++ on the (2+STABLE_CYCLES)th rising edge after the change.
- Glitch rejection: a value that lasts fewer than STABLE_CYCLES post-sync cycles is never accepted.
- FSM:
  - IDLE -> RUN when enable=1. On that edge: latch exp_codes into the shadow, clear cycles and step_idx.
  - RUN:
    - Accept == shadow[step_idx]: step_idx++, step_pulse=1. Step 0 also sets started.
    - If that was step NUM_STEPS-1 -> PASS.
    - STRICT=1 and step_idx>0 and accept matches neither shadow[step_idx] nor shadow[step_idx-1]: go to FAIL, set fail_code = accepted value.
    - STRICT=1 and step_idx==0: non-matching values are ignored (pre-start noise).
    - When cycles reaches TIMEOUT_CYCLES-1 without completing: go to FAIL with timeout=1.
  - PASS and FAIL are terminal. Outputs are held until enable=0.
  - Any state -> IDLE when enable=0. That edge clears all outputs except cycles, which holds its last value until the next arm.
- Simultaneous events on the same edge:
  - A final match wins over timeout: result is PASS, timeout=0.
  - A strict violation wins over timeout: fail_code is valid, timeout=0.
  - enable=0 wins over everything.
- Duplicate codes in exp_codes (e.g. the same code at k and k+1): step k+1 requires the value to leave and re-enter, because acceptance is edge-based.
- cycles increments only in RUN and saturates at all-ones. Counter arithmetic is unsigned CNT_W.
- Mid-run reset: immediate return to IDLE with all state cleared. The monitor does not re-arm until resetb is high and enable is seen high on a clock edge.

Decomposition:
- Package mprj_monitor_pkg:
  - state encoding constants (IDLE, RUN, PASS, FAIL as 2-bit values)
  - default checkpoint constants (CP_WB_START = 16'hAB60, CP_WB_DONE = 16'hAB61)
- Sub-module mprj_stable_filter (parameters WIDTH, STABLE_CYCLES): synchroniser, stability counter and accept strobe/value. The top level holds the FSM, shadow registers and counters.

Test Plan:
- Defaults, exp={AB61,AB60}, drive 0000 -> AB60 -> AB61, each held 10 cycles -> started at AB60 accept, step_idx 1 then 2, pass=1, fail=0, cycles frozen.
- Single-cycle glitch AB60 then back to 0000, STABLE_CYCLES=2 -> no step_pulse, step_idx=0; no pass before TIMEOUT_CYCLES.
- TIMEOUT_CYCLES=100, hold 0000 -> fail=1 and timeout=1 exactly 100 cycles after arm; cycles=99 and holds.
- STRICT=1, drive AB60 then 1234 -> fail=1, fail_code=16'h1234, timeout=0, step_idx=1.
- AB61 accepted on the same edge the timeout would fire -> pass=1, timeout=0. Then enable=0 -> all flags clear; re-arm works.
- Assert resetb low while step_idx=1 -> all outputs 0 asynchronously; after release and enable=1, the sequence restarts from step 0.

Source files
------------

// File: rtl/mprj_monitor_pkg.sv
// Shared constants for the checkpoint monitor: FSM state encoding and the
// default wb_port checkpoint codes.
package mprj_monitor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [15:0] CP_WB_START = 16'hAB60;
  localparam logic [15:0] CP_WB_DONE  = 16'hAB61;

endpackage

// File: rtl/mprj_stable_filter.sv
// Two-flop synchroniser plus stability counter; emits one registered accept
// strobe each time the synchronised value has held for STABLE_CYCLES samples.
module mprj_stable_filter
  import mprj_monitor_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] din,
  output logic             accept,
  output logic [WIDTH-1:0] value
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             same_s;
  logic             fire_s;

  // cnt_r counts how many consecutive samples sync2_r has held its value
  always_comb begin
    same_s = (sync1_r == sync2_r);
    if (!same_s) begin
      cnt_nxt_s = CW'(1);
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = CNT_MAX;
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
    fire_s = (cnt_nxt_s == CNT_MAX) && !(same_s && (cnt_r == CNT_MAX));
  end

  // Synchroniser, stability counter and accept strobe registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync1_r <= '0;
      sync2_r <= '0;
      cnt_r   <= '0;
      accept  <= 1'b0;
      value   <= '0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      cnt_r   <= cnt_nxt_s;
      accept  <= fire_s;
      value   <= fire_s ? sync1_r : value;
    end
  end

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint sequencer: watches a filtered GPIO field for an ordered list of
// codes and reports pass, fail (strict violation) or timeout.
module mprj_checkpoint_monitor
  import mprj_monitor_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NUM_STEPS      = 2,
  parameter int STEP_W         = 3,
  parameter int TIMEOUT_CYCLES = 70000,
  parameter int CNT_W          = 17,
  parameter int STABLE_CYCLES  = 2,
  parameter int STRICT         = 0
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       enable,
  input  logic [WIDTH-1:0]           checkbits,
  input  logic [NUM_STEPS*WIDTH-1:0] exp_codes,
  output logic [STEP_W-1:0]          step_idx,
  output logic                       step_pulse,
  output logic                       started,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout,
  output logic [WIDTH-1:0]           fail_code,
  output logic [CNT_W-1:0]           cycles
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]                 state_r;
  logic [NUM_STEPS*WIDTH-1:0] shadow_r;
  logic                       acc_s;
  logic [WIDTH-1:0]           acc_val_s;
  logic [WIDTH-1:0]           cur_code_s;
  logic [WIDTH-1:0]           prev_code_s;
  logic                       hit_s;
  logic                       prev_hit_s;
  logic                       viol_s;
  logic                       last_s;
  logic                       to_hit_s;

  mprj_stable_filter #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock (clock),
    .resetb(resetb),
    .din   (checkbits),
    .accept(acc_s),
    .value (acc_val_s)
  );

  // Current/previous expected code selection and event decode
  always_comb begin
    cur_code_s  = '0;
    prev_code_s = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      cur_code_s  = (step_idx == STEP_W'(k))     ? shadow_r[k*WIDTH +: WIDTH] : cur_code_s;
      prev_code_s = (step_idx == STEP_W'(k + 1)) ? shadow_r[k*WIDTH +: WIDTH] : prev_code_s;
    end
    hit_s      = acc_s && (acc_val_s == cur_code_s);
    prev_hit_s = (step_idx != '0) && (acc_val_s == prev_code_s);
    viol_s     = (STRICT != 0) && acc_s && (step_idx != '0) && !hit_s && !prev_hit_s;
    last_s     = (step_idx == STEP_W'(NUM_STEPS - 1));
    to_hit_s   = TO_EN && (cycles == TO_LAST);
  end

  // Sequencer FSM; priority inside RUN is final match, strict violation, timeout
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_r    <= ST_IDLE;
      shadow_r   <= '0;
      step_idx   <= '0;
      step_pulse <= 1'b0;
      started    <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
      timeout    <= 1'b0;
      fail_code  <= '0;
      cycles     <= '0;
    end else begin
      step_pulse <= 1'b0;
      if (!enable) begin
        state_r   <= ST_IDLE;
        step_idx  <= '0;
        started   <= 1'b0;
        pass      <= 1'b0;
        fail      <= 1'b0;
        timeout   <= 1'b0;
        fail_code <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r  <= ST_RUN;
            shadow_r <= exp_codes;
            cycles   <= '0;
            step_idx <= '0;
          end
          ST_RUN: begin
            if (hit_s && last_s) begin
              step_idx   <= step_idx + STEP_W'(1);
              step_pulse <= 1'b1;
              started    <= 1'b1;
              pass       <= 1'b1;
              state_r    <= ST_PASS;
            end else if (viol_s) begin
              fail      <= 1'b1;
              fail_code <= acc_val_s;
              state_r   <= ST_FAIL;
            end else if (to_hit_s) begin
              fail    <= 1'b1;
              timeout <= 1'b1;
              state_r <= ST_FAIL;
            end else begin
              if (hit_s) begin
                step_idx   <= step_idx + STEP_W'(1);
                step_pulse <= 1'b1;
                started    <= 1'b1;
              end
              cycles <= (cycles == '1) ? cycles : cycles + CNT_W'(1);
            end
          end
          ST_PASS, ST_FAIL: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
